// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants, register map and FSM states for the SPI register interface
package spi_reg_pkg;
  localparam int SPI_FRAME_BITS = 16;
  localparam logic SPI_WR_BIT = 1'b1;
  localparam logic [6:0] REG_EN_OUT_7_0 = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0 = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY = 7'h04;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} spi_state_t;
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(input logic [6:0] a, input logic [7:0] d);
    return {SPI_WR_BIT, a, d};
  endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: one-cycle tick every CLK_DIV clocks while enabled, cleared when disabled
module spi_half_tick #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  logic [CNT_W-1:0] cnt;
  assign tick = en && cnt == LAST;
  // half-period counter: 0..CLK_DIV-1, wraps on tick, held at zero while idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: mode-0 SPI initiator sending one 16-bit register-write frame per start
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);
  spi_state_t state;
  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [SPI_FRAME_BITS-1:0] frame;
  logic [3:0] idx;
  logic tick;
  assign frame = spi_frame(addr, wdata);
  spi_half_tick #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .en(state != IDLE),
    .tick(tick)
  );
  // frame sequencer: every phase lasts one half-period tick; copi changes only on sclk falling edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      sclk <= 1'b0;
      copi <= 1'b0;
      ncs <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start && !busy) begin
            shreg <= frame;
            copi <= frame[SPI_FRAME_BITS-1];
            idx <= 4'd15;
            ncs <= 1'b0;
            busy <= 1'b1;
            state <= SETUP;
          end
        SETUP:
          if (tick) begin
            sclk <= 1'b1;
            state <= HIGH;
          end
        HIGH:
          if (tick) begin
            sclk <= 1'b0;
            if (idx != 4'd0) begin
              copi <= shreg[SPI_FRAME_BITS-2];
              shreg <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
              state <= LOW;
            end else state <= HOLD;
          end
        LOW:
          if (tick) begin
            sclk <= 1'b1;
            idx <= idx - 4'd1;
            state <= HIGH;
          end
        HOLD:
          if (tick) begin
            ncs <= 1'b1;
            copi <= 1'b0;
            done <= 1'b1;
            state <= GAP;
          end
        GAP:
          if (tick) begin
            busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: scoreboarded check of SPI frames at CLK_DIV=4 and CLK_DIV=2
module tb_spi_reg_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start_v = '0;
  logic [6:0] addr_v[2];
  logic [7:0] wdata_v[2];
  logic [1:0] busy_v, done_v, sclk_v, copi_v, ncs_v;
  int tests = 0;
  int fails = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int nn[2] = '{4, 2};
  int low_cnt[2], rises[2], run_hi[2], run_lo[2], busy_cnt[2], done_run[2], since_done[2], hi_gap[2], last_gap[2];
  logic [15:0] shf[2];
  logic in_f[2], p_sclk[2], p_ncs[2], p_busy[2], p_done[2];
  typedef struct {
    int d;
    logic [6:0] a;
    logic [7:0] w;
    logic [15:0] f;
    bit scr;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  spi_reg_controller #(.CLK_DIV(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .copi(copi_v[0]), .ncs(ncs_v[0])
  );
  spi_reg_controller #(.CLK_DIV(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .copi(copi_v[1]), .ncs(ncs_v[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // bus monitor: rebuild each frame from copi at sclk rises and check the frame timing
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        in_f[d] = 1'b0;
        busy_cnt[d] = 0;
        done_run[d] = 0;
      end else begin
        since_done[d]++;
        if (p_ncs[d] && !ncs_v[d]) begin
          in_f[d] = 1'b1;
          low_cnt[d] = 0;
          rises[d] = 0;
          shf[d] = '0;
          run_hi[d] = 0;
          run_lo[d] = 0;
          last_gap[d] = hi_gap[d];
        end
        if (!ncs_v[d]) low_cnt[d]++;
        if (ncs_v[d] && sclk_v[d]) chk("sclk_idle_low", 1, 0);
        if (in_f[d] && !ncs_v[d]) begin
          if (!p_sclk[d] && sclk_v[d]) begin
            if (rises[d] > 0) chk("sclk_low_phase", run_lo[d], nn[d]);
            rises[d]++;
            shf[d] = {shf[d][14:0], copi_v[d]};
            run_hi[d] = 0;
          end
          if (p_sclk[d] && !sclk_v[d]) begin
            chk("sclk_high_phase", run_hi[d], nn[d]);
            run_lo[d] = 0;
          end
          if (sclk_v[d]) run_hi[d]++;
          else run_lo[d]++;
        end
        if (in_f[d] && !p_ncs[d] && ncs_v[d]) begin
          if (d == 0 ? q0.size() == 0 : q1.size() == 0) chk("frame_unexpected", 1, 0);
          else chk("frame", int'(shf[d]), int'(d == 0 ? q0.pop_front() : q1.pop_front()));
          chk("sclk_rises", rises[d], 16);
          chk("ncs_low_len", low_cnt[d], 33 * nn[d]);
          chk("done_at_ncs_rise", int'(done_v[d]), 1);
          in_f[d] = 1'b0;
          since_done[d] = 0;
          hi_gap[d] = 0;
        end else if (done_v[d]) chk("done_stray", 1, 0);
        if (ncs_v[d]) hi_gap[d]++;
        if (done_v[d]) done_run[d]++;
        else if (p_done[d]) begin
          chk("done_width", done_run[d], 1);
          done_run[d] = 0;
        end
        if (busy_v[d]) busy_cnt[d]++;
        else if (p_busy[d]) begin
          chk("busy_len", busy_cnt[d], 34 * nn[d]);
          chk("busy_after_done", since_done[d], nn[d]);
          busy_cnt[d] = 0;
        end
      end
      p_sclk[d] = sclk_v[d];
      p_ncs[d] = ncs_v[d];
      p_busy[d] = busy_v[d];
      p_done[d] = done_v[d];
    end

  task automatic send(input int d, input logic [6:0] a, input logic [7:0] w, input logic [15:0] f, input bit scr);
    int t = 0;
    while (busy_v[d] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (d == 0) q0.push_back(f);
    else q1.push_back(f);
    addr_v[d] = a;
    wdata_v[d] = w;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    while (scr && busy_v[d] && t < 2000) begin
      addr_v[d] = 7'($urandom);
      wdata_v[d] = 8'($urandom);
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((busy_v[d] || (d == 0 ? q0.size() : q1.size()) != 0) && t < 2000);
    if (t >= 2000) chk("idle_timeout", 1, 0);
    chk("queue_empty", d == 0 ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr_v[d] = '0;
      wdata_v[d] = '0;
      in_f[d] = 1'b0;
      p_sclk[d] = 1'b0;
      p_ncs[d] = 1'b1;
      p_busy[d] = 1'b0;
      p_done[d] = 1'b0;
      low_cnt[d] = 0; rises[d] = 0; run_hi[d] = 0; run_lo[d] = 0; busy_cnt[d] = 0;
      done_run[d] = 0; since_done[d] = 0; hi_gap[d] = 0; last_gap[d] = 0;
      shf[d] = '0;
    end
    vt[0] = '{0, 7'h04, 8'h80, 16'h8480, 1'b0};
    vt[1] = '{0, 7'h00, 8'hFF, 16'h80FF, 1'b0};
    vt[2] = '{0, 7'h02, 8'h01, 16'h8201, 1'b0};
    vt[3] = '{0, 7'h7F, 8'hFF, 16'hFFFF, 1'b0};
    vt[4] = '{0, 7'h05, 8'h00, 16'h8500, 1'b0};
    vt[5] = '{1, 7'h7F, 8'h00, 16'hFF00, 1'b0};
    vt[6] = '{1, 7'h03, 8'h5A, 16'h835A, 1'b0};
    vt[7] = '{0, 7'h15, 8'h3C, 16'h953C, 1'b1};
    vt[8] = '{1, 7'h66, 8'h99, 16'hE699, 1'b1};
    vt[9] = '{0, 7'h01, 8'hA5, 16'h81A5, 1'b0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ncs", int'(ncs_v[d]), 1);
      chk("rst_sclk", int'(sclk_v[d]), 0);
      chk("rst_copi", int'(copi_v[d]), 0);
      chk("rst_busy", int'(busy_v[d]), 0);
      chk("rst_done", int'(done_v[d]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      send(vt[i].d, vt[i].a, vt[i].w, vt[i].f, vt[i].scr);
      wait_idle(vt[i].d);
    end
    q0.push_back(16'h81A5);
    q0.push_back(16'h81A5);
    addr_v[0] = 7'h01;
    wdata_v[0] = 8'hA5;
    start_v[0] = 1'b1;
    repeat (200) @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);
    chk("b2b_ncs_high_gap", last_gap[0], 5);
    send(0, 7'h04, 8'h3C, 16'h843C, 1'b0);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      #2;
      if (rises[0] >= 5) break;
    end
    chk("rises_before_reset", rises[0], 5);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("midrst_ncs", int'(ncs_v[0]), 1);
    chk("midrst_sclk", int'(sclk_v[0]), 0);
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_done", int'(done_v[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 7'h02, 8'hC3, 16'h82C3, 1'b0);
    wait_idle(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
- SPI initiator that drives register-write frames into the chip's SPI register-file peripheral over the SCLK/COPI/nCS pins.
- The peripheral's registers feed the PWM block: output enables, PWM enables and duty cycle.
- Used as a bench or FPGA-side driver and as a reusable initiator core; accepts one address/data write per start pulse.
- Write-only, SPI mode 0, MSB first, 16-bit frames.

Parameters:
- CLK_DIV, default 4: number of clk cycles per SCLK half-period. Legal values are 2..255. A value of 4 or more is required for the peripheral's 2-FF input synchronisers.
- CNT_W, default 8: width of the half-period counter. Must satisfy 2^CNT_W > CLK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a write; sampled on clk rising edge; only accepted when busy=0
- addr  input  7  register address; latched when start is accepted
- wdata  input  8  write data; latched when start is accepted
- busy  output  1  high from the accept edge through the end of the GAP phase
- done  output  1  one-cycle pulse marking frame completion
- sclk  output  1  SPI clock; idles low
- copi  output  1  SPI data out
- ncs  output  1  SPI chip select, active low

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): ncs=1, sclk=0, copi=0, busy=0, done=0, state=IDLE, counters=0. A partial frame is abandoned. The peripheral discards it because ncs rises.
- Frame format: shift register = {1'b1 (write), addr[6:0], wdata[7:0]}. Bit 15 is sent first.
- Let N = CLK_DIV. All outputs are registered.
- IDLE: on a clk edge with start=1 and busy=0, latch the frame and enter SETUP. On that same edge: ncs=0, copi=bit15, busy=1.
- SETUP (N cycles): sclk=0, ncs=0. Then enter HIGH for bit index 15.
- HIGH (N cycles): sclk=1. copi is stable for the whole phase; the peripheral samples on the rising edge.
  - At the end of HIGH for bits 15..1: sclk=0, copi takes the next bit on the same edge, enter LOW.
  - At the end of HIGH for bit 0: sclk=0, enter HOLD. copi holds bit 0.
- LOW (N cycles): sclk=0. Then enter HIGH for the next bit.
- HOLD (N cycles): sclk=0, ncs=0.
- Leaving HOLD: ncs=1, copi=0, done=1 for exactly that one cycle, enter GAP.
- GAP (N cycles): ncs=1, busy=1. At the end of GAP, busy=0 and return to IDLE.
- Timing totals:
  - ncs is low for exactly 33N clk cycles (132 at N=4).
  - Exactly 16 sclk rising edges occur per frame.
  - busy is high for 34N cycles.
- start while busy=1 (including the done cycle and GAP) is ignored: no queueing, no error.
- start in the first cycle with busy=0 is accepted. Back-to-back frames are separated by at least N cycles of ncs high.
- addr/wdata changes after acceptance have no effect on the frame in flight.
- The address is not range-checked: addresses 0x05..0x7F are transmitted as given.
- The half-period counter counts 0..N-1 and wraps. The bit index counts 15 down to 0 and never wraps within a frame.

Decomposition:
- Shared package spi_reg_pkg:
  - SPI_FRAME_BITS=16
  - SPI_WR_BIT=1'b1
  - register addresses: REG_EN_OUT_7_0=7'h00, REG_EN_OUT_15_8=7'h01, REG_EN_PWM_7_0=7'h02, REG_EN_PWM_15_8=7'h03, REG_PWM_DUTY=7'h04
  - state typedef: IDLE, SETUP, HIGH, LOW, HOLD, GAP
  - The register-file peripheral uses the same package.
- One sub-module: spi_half_tick, a CNT_W-bit counter that emits a one-cycle tick every CLK_DIV cycles while enabled and clears when disabled.
- The FSM and shift register live in spi_reg_controller.

Test Plan:
- Single write, N=4: addr=0x04, wdata=0x80, start pulsed for 1 cycle.
  - Capture copi at sclk rising edges -> 0x8480, MSB first.
  - ncs low for 132 cycles; exactly 16 sclk rises.
  - done high for exactly 1 cycle, coincident with ncs rising; busy low 4 cycles later.
- Loopback through the chip's SPI peripheral and PWM path:
  - Write 0x00=0xFF -> uo_out=0xFF.
  - Write 0x02=0x01 and 0x04=0x80 -> uo_out[0] toggles at a 50% duty cycle.
- start held high for 200 cycles with addr=0x01, wdata=0xA5 -> exactly one frame 0x81A5 during busy, then a second frame accepted the cycle busy falls.
- Assert rst_n=0 after the 5th sclk rise -> same cycle: ncs=1, sclk=0, busy=0, no done. A new start after release sends a complete, correct frame.
- N=2 parameterisation: addr=0x7F, wdata=0x00 -> frame 0xFF00; ncs low 66 cycles; sclk high and low phases of exactly 2 cycles each.
- addr/wdata changed to random values every cycle while busy -> transmitted frame equals the values latched at acceptance.
